debounce_bank: RTL and testbench
================================

Name: debounce_bank

Overview:
- Multi-channel successor to the single-switch debouncer, with NUM_CH independent lanes.
- Per lane: 2-flop input synchronizer, stability-counter debounce, and one-cycle press/release pulses.
- Per lane: optional long-press detect with auto-repeat pulses.
- Sits between board buttons/switches and game/UI logic, e.g. paddle up/down held to auto-step.

Parameters:
- NUM_CH, 4: number of independent switch lanes (>=1).
- DEBOUNCE_LIMIT, 250000: cycles the synchronized input must differ from the debounced state before the state updates (10 ms at 25 MHz; >=1).
- HOLD_LIMIT, 12500000: cycles o_Switch must stay 1 before the first o_Repeat pulse (0.5 s; >=1).
- REPEAT_LIMIT, 2500000: cycles between subsequent o_Repeat pulses. 0 = a single long-press pulse, no auto-repeat.

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  synchronous reset, active low
- i_Switch  in  NUM_CH  raw asynchronous switch inputs; bit n = lane n
- o_Switch  out  NUM_CH  debounced level per lane
- o_Rise  out  NUM_CH  1-cycle pulse when o_Switch[n] goes 0->1
- o_Fall  out  NUM_CH  1-cycle pulse when o_Switch[n] goes 1->0
- o_Repeat  out  NUM_CH  1-cycle long-press / auto-repeat pulse

Behaviour:
- Interface: one clock, i_Clk. Reset i_Rst_L is synchronous and active-low.
- Reset:
  - While i_Rst_L=0 at a rising edge, all registers clear: sync flops, debounced state, counters, FSM=IDLE.
  - Output reset values: o_Switch=0, o_Rise=0, o_Fall=0, o_Repeat=0.
  - Reset mid-count or mid-hold abandons that count; no pulse is emitted.
- Lanes are fully independent; there is no cross-lane arbitration or shared counter.
- Synchronizer: sync1<=i_Switch, sync2<=sync1. Only sync2 feeds the debounce logic.
- Debounce counter, width $clog2(DEBOUNCE_LIMIT+1):
  - sync2!=state and cnt<LIMIT -> cnt+1.
  - cnt==LIMIT -> state<=sync2, cnt<=0.
  - Otherwise -> cnt<=0. Any glitch shorter than LIMIT cycles restarts the count.
- Latency: an input step held stable changes o_Switch at the (DEBOUNCE_LIMIT+3)th rising edge after the step.
- Edge pulses:
  - o_Rise/o_Fall are registered and assert in the same cycle o_Switch changes, for exactly 1 cycle.
  - o_Rise and o_Fall are never both high on one lane.
- Hold FSM per lane, states IDLE, HOLD, REPEAT, DONE; hold counter width $clog2(max(HOLD_LIMIT,REPEAT_LIMIT)+1):
  - IDLE: on rise -> HOLD, hcnt<=1.
  - HOLD: hcnt+1 each cycle. When hcnt==HOLD_LIMIT, pulse o_Repeat and hcnt<=1, then go to REPEAT (REPEAT_LIMIT>0) or DONE (REPEAT_LIMIT==0).
  - REPEAT: hcnt+1. When hcnt==REPEAT_LIMIT, pulse o_Repeat and hcnt<=1.
  - DONE: wait.
  - In any state, a fall -> IDLE, hcnt<=0, and no o_Repeat that cycle; fall has priority over a coincident terminal count.
- Pulse timing: the first o_Repeat comes HOLD_LIMIT cycles after o_Rise; each later one comes REPEAT_LIMIT cycles after the previous.
- Counters never wrap. Comparisons use ==, and every counter clears on reaching its limit.

Decomposition:
- Package debounce_pkg holds:
  - FSM state encoding: IDLE=2'd0, HOLD=2'd1, REPEAT=2'd2, DONE=2'd3.
  - A constant function for counter width (clog2 of limit+1).
  - Default timing constants for 25 MHz.
- Sub-module debounce_channel: one lane (sync + debounce + edge + hold FSM), same parameters minus NUM_CH.
- debounce_bank instantiates NUM_CH copies in a generate loop.

Test Plan:
All tests use NUM_CH=4, DEBOUNCE_LIMIT=4, HOLD_LIMIT=10, REPEAT_LIMIT=3.
1. Reset: hold i_Rst_L=0 for 3 cycles with i_Switch=4'hF -> all outputs 0. Release -> o_Switch=4'hF at edge 7 after release, with o_Rise=4'hF for 1 cycle.
2. Bounce: i_Switch[0] toggles 1,0,1,0 with 2-cycle widths, then holds 1 -> no o_Switch/o_Rise change during bounce. o_Switch[0]=1 exactly 7 edges after the final step.
3. Release: lane 1 pressed, then stable 0 -> single o_Fall[1] pulse; o_Rise[1] and o_Repeat[1] stay 0 that cycle.
4. Long press: lane 2 held 1 for 25 cycles after o_Rise -> o_Repeat[2] pulses at +10, +13, +16, +19, +22, +25. Release -> no further pulses.
5. Single-shot: REPEAT_LIMIT=0, lane 3 held 40 cycles -> exactly one o_Repeat at +10. Fall on the same cycle as a terminal count -> o_Fall only.
6. Independence and reset: lanes 0 and 2 pressed simultaneously at different offsets -> correct per-lane timing. Asserting i_Rst_L=0 mid-HOLD clears every output on the next edge, with no stray pulse after release.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce bank: hold-FSM encoding,
// counter width helper and default 25 MHz timing.
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2,
      DONE   = 2'd3
   } hold_state_t;

   localparam int DEF_DEBOUNCE_LIMIT = 250000;    // 10 ms
   localparam int DEF_HOLD_LIMIT     = 12500000;  // 0.5 s
   localparam int DEF_REPEAT_LIMIT   = 2500000;   // 0.1 s

   // Bits needed to count 0..limit inclusive.
   function automatic int cnt_w(input int limit);
      return $clog2(limit + 1);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Switch-in / event-out bundle between board switches and the debounce bank.
interface debounce_bank_if #(
   parameter int NUM_CH = 4
);
   logic [NUM_CH-1:0] i_Switch;
   logic [NUM_CH-1:0] o_Switch;
   logic [NUM_CH-1:0] o_Rise;
   logic [NUM_CH-1:0] o_Fall;
   logic [NUM_CH-1:0] o_Repeat;

   modport master (output i_Switch, input o_Switch, o_Rise, o_Fall, o_Repeat);
   modport slave  (input i_Switch, output o_Switch, o_Rise, o_Fall, o_Repeat);
endinterface

// File: rtl/debounce_channel.sv
// One switch lane: 2-flop synchronizer, stability-count debounce, registered
// edge pulses and a long-press / auto-repeat FSM.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
   parameter int HOLD_LIMIT     = DEF_HOLD_LIMIT,
   parameter int REPEAT_LIMIT   = DEF_REPEAT_LIMIT
) (
   input  logic i_Clk,
   input  logic i_Rst_L,
   input  logic i_Switch,
   output logic o_Switch,
   output logic o_Rise,
   output logic o_Fall,
   output logic o_Repeat
);

   localparam int DW = cnt_w(DEBOUNCE_LIMIT);
   localparam int HW = cnt_w(max2(HOLD_LIMIT, REPEAT_LIMIT));
   localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_LIMIT);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LIMIT);
   localparam logic [HW-1:0] REP_MAX  = HW'(REPEAT_LIMIT);

   logic          sync1, sync2;
   logic          state;
   logic [DW-1:0] cnt;
   logic          rise_q, fall_q;

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         state  <= 1'b0;
         cnt    <= '0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync1  <= i_Switch;
         sync2  <= sync1;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         // Terminal count commits whatever sync2 holds now; pulses only on a real change.
         if (cnt == DB_MAX) begin
            state  <= sync2;
            cnt    <= '0;
            rise_q <= sync2 & ~state;
            fall_q <= ~sync2 & state;
         end else if (sync2 != state) begin
            cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
      end
   end

   hold_state_t   hstate, hstate_nxt;
   logic [HW-1:0] hcnt, hcnt_nxt;
   logic          rep;

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         hstate <= IDLE;
         hcnt   <= '0;
      end else begin
         hstate <= hstate_nxt;
         hcnt   <= hcnt_nxt;
      end
   end

   // A release wins over a coincident terminal count, suppressing that pulse.
   always_comb begin
      hstate_nxt = hstate;
      hcnt_nxt   = hcnt;
      rep        = 1'b0;
      if (fall_q) begin
         hstate_nxt = IDLE;
         hcnt_nxt   = '0;
      end else begin
         case (hstate)
            IDLE: begin
               if (rise_q) begin
                  hstate_nxt = HOLD;
                  hcnt_nxt   = HW'(1);
               end
            end
            HOLD: begin
               if (hcnt == HOLD_MAX) begin
                  rep        = 1'b1;
                  hcnt_nxt   = HW'(1);
                  hstate_nxt = (REPEAT_LIMIT > 0) ? REPEAT : DONE;
               end else begin
                  hcnt_nxt = hcnt + 1'b1;
               end
            end
            REPEAT: begin
               if (hcnt == REP_MAX) begin
                  rep      = 1'b1;
                  hcnt_nxt = HW'(1);
               end else begin
                  hcnt_nxt = hcnt + 1'b1;
               end
            end
            DONE: ;
            default: begin
               hstate_nxt = IDLE;
               hcnt_nxt   = '0;
            end
         endcase
      end
   end

   assign o_Switch = state;
   assign o_Rise   = rise_q;
   assign o_Fall   = fall_q;
   assign o_Repeat = rep;

endmodule

// File: rtl/debounce_bank.sv
// NUM_CH independent debounce lanes behind one interface; no shared state.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT,
   parameter int HOLD_LIMIT     = DEF_HOLD_LIMIT,
   parameter int REPEAT_LIMIT   = DEF_REPEAT_LIMIT
) (
   input  logic           i_Clk,
   input  logic           i_Rst_L,
   debounce_bank_if.slave bus
);

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
         .HOLD_LIMIT     (HOLD_LIMIT),
         .REPEAT_LIMIT   (REPEAT_LIMIT)
      ) u_ch (
         .i_Clk    (i_Clk),
         .i_Rst_L  (i_Rst_L),
         .i_Switch (bus.i_Switch[n]),
         .o_Switch (bus.o_Switch[n]),
         .o_Rise   (bus.o_Rise[n]),
         .o_Fall   (bus.o_Fall[n]),
         .o_Repeat (bus.o_Repeat[n])
      );
   end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: two DUTs (auto-repeat and single-shot) share one
// stimulus and are compared every cycle against an event-level lane model.
module tb_debounce_bank;
   import debounce_pkg::*;

   localparam int NCH = 4;
   localparam int DB  = 4;
   localparam int HL  = 10;

   logic           i_Clk   = 1'b0;
   logic           i_Rst_L = 1'b0;
   logic [NCH-1:0] sw      = '0;

   always #5 i_Clk = ~i_Clk;

   debounce_bank_if #(.NUM_CH(NCH)) bus_a ();
   debounce_bank_if #(.NUM_CH(NCH)) bus_b ();
   assign bus_a.i_Switch = sw;
   assign bus_b.i_Switch = sw;

   debounce_bank #(.NUM_CH(NCH), .DEBOUNCE_LIMIT(DB), .HOLD_LIMIT(HL), .REPEAT_LIMIT(3))
      dut_a (.i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .bus(bus_a));
   debounce_bank #(.NUM_CH(NCH), .DEBOUNCE_LIMIT(DB), .HOLD_LIMIT(HL), .REPEAT_LIMIT(0))
      dut_b (.i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .bus(bus_b));

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h want %0h", tag, $time, got, exp);
      end
   endtask

   // Reference: input seen two edges late; level flips once it has differed
   // for DB consecutive edges; repeat pulses at fixed ages since the rise.
   int m_s1[2][NCH], m_s2[2][NCH], m_lvl[2][NCH], m_run[2][NCH], m_age[2][NCH];
   bit m_rise[2][NCH], m_fall[2][NCH];

   function automatic int rl(input int d);
      return (d == 0) ? 3 : 0;
   endfunction

   function automatic bit rep_exp(input int d, input int l);
      int a;
      a = m_age[d][l];
      if (m_lvl[d][l] == 0) return 1'b0;
      if (a == HL) return 1'b1;
      return (rl(d) > 0) && (a > HL) && ((a - HL) % rl(d) == 0);
   endfunction

   always @(posedge i_Clk) begin
      for (int d = 0; d < 2; d++) begin
         for (int l = 0; l < NCH; l++) begin
            m_rise[d][l] = 1'b0;
            m_fall[d][l] = 1'b0;
            if (!i_Rst_L) begin
               m_s1[d][l] = 0; m_s2[d][l] = 0; m_lvl[d][l] = 0;
               m_run[d][l] = 0; m_age[d][l] = 0;
            end else begin
               m_age[d][l] = m_age[d][l] + 1;
               if (m_run[d][l] == DB) begin
                  m_run[d][l] = 0;
                  if (m_s2[d][l] != m_lvl[d][l]) begin
                     m_lvl[d][l]  = m_s2[d][l];
                     m_rise[d][l] = (m_s2[d][l] == 1);
                     m_fall[d][l] = (m_s2[d][l] == 0);
                     m_age[d][l]  = 0;
                  end
               end else begin
                  m_run[d][l] = (m_s2[d][l] != m_lvl[d][l]) ? m_run[d][l] + 1 : 0;
               end
               m_s2[d][l] = m_s1[d][l];
               m_s1[d][l] = int'(sw[l]);
            end
         end
      end
   end

   task automatic cmp_dut(input int d, input logic [NCH-1:0] g_sw, input logic [NCH-1:0] g_r,
                          input logic [NCH-1:0] g_f, input logic [NCH-1:0] g_rp);
      logic [NCH-1:0] e_sw, e_r, e_f, e_rp;
      for (int l = 0; l < NCH; l++) begin
         e_sw[l] = (m_lvl[d][l] != 0);
         e_r[l]  = m_rise[d][l];
         e_f[l]  = m_fall[d][l];
         e_rp[l] = rep_exp(d, l);
      end
      chk($sformatf("sw%0d", d),  32'(g_sw), 32'(e_sw));
      chk($sformatf("rise%0d", d), 32'(g_r),  32'(e_r));
      chk($sformatf("fall%0d", d), 32'(g_f),  32'(e_f));
      chk($sformatf("rep%0d", d),  32'(g_rp), 32'(e_rp));
   endtask

   always @(negedge i_Clk) begin
      if (chk_en) begin
         cmp_dut(0, bus_a.o_Switch, bus_a.o_Rise, bus_a.o_Fall, bus_a.o_Repeat);
         cmp_dut(1, bus_b.o_Switch, bus_b.o_Rise, bus_b.o_Fall, bus_b.o_Repeat);
      end
   end

   // Counts edges (sampled #1 after each) until lane l of the chosen DUT shows o_Rise.
   task automatic wait_rise(input int d, input int l, output int k);
      k = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge i_Clk); #1;
         if ((d == 0 ? bus_a.o_Rise[l] : bus_b.o_Rise[l]) === 1'b1) begin
            k = i;
            break;
         end
      end
   endtask

   initial begin
      int k, np, first;
      int hold_left[NCH];

      // 1: reset with all switches pressed, then release latency
      sw = 4'hF;
      i_Rst_L = 1'b0;
      @(negedge i_Clk);
      chk_en = 1'b1;
      repeat (2) @(negedge i_Clk);
      chk("rst_sw", 32'(bus_a.o_Switch | bus_b.o_Switch), 32'h0);
      chk("rst_ev", 32'(bus_a.o_Rise | bus_a.o_Fall | bus_a.o_Repeat), 32'h0);
      i_Rst_L = 1'b1;
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge i_Clk); #1;
         if (bus_a.o_Switch === 4'hF) begin k = i; break; end
      end
      chk("rel_lat", 32'(k), 32'd7);
      chk("rel_rise", 32'(bus_a.o_Rise), 32'hF);
      @(negedge i_Clk);
      sw = 4'h0;
      repeat (20) @(negedge i_Clk);

      // 2: bounce on lane 0, then a clean step
      for (int i = 0; i < 8; i++) begin
         sw[0] = (i % 4) < 2;
         @(negedge i_Clk);
      end
      sw[0] = 1'b1;
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge i_Clk); #1;
         if (bus_a.o_Switch[0] === 1'b1) begin k = i; break; end
      end
      chk("bounce_lat", 32'(k), 32'd7);
      @(negedge i_Clk);
      sw[0] = 1'b0;
      repeat (12) @(negedge i_Clk);

      // 3+5: release on lane 1 landing on a repeat terminal count (age 13)
      sw[1] = 1'b1;
      wait_rise(0, 1, k);
      chk("l1_rise_seen", 32'(k != 0), 32'd1);
      repeat (7) @(negedge i_Clk);
      sw[1] = 1'b0;
      repeat (7) @(posedge i_Clk);
      #1;
      chk("coinc_fall", 32'(bus_a.o_Fall[1]), 32'd1);
      chk("coinc_rep", 32'(bus_a.o_Repeat[1]), 32'd0);
      chk("coinc_rise", 32'(bus_a.o_Rise[1]), 32'd0);
      repeat (12) @(negedge i_Clk);

      // 4: long press on lane 2, count repeat pulses in the first 25 cycles
      sw[2] = 1'b1;
      wait_rise(0, 2, k);
      np = 0; first = 0;
      for (int i = 1; i <= 25; i++) begin
         @(posedge i_Clk); #1;
         if (bus_a.o_Repeat[2] === 1'b1) begin
            np++;
            if (first == 0) first = i;
         end
      end
      chk("long_cnt", 32'(np), 32'd6);
      chk("long_first", 32'(first), 32'd10);
      @(negedge i_Clk);
      sw[2] = 1'b0;
      repeat (15) @(negedge i_Clk);

      // 5: single-shot DUT, lane 3 held 40 cycles, then fall on its terminal count
      sw[3] = 1'b1;
      wait_rise(1, 3, k);
      np = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge i_Clk); #1;
         if (bus_b.o_Repeat[3] === 1'b1) np++;
      end
      chk("single_cnt", 32'(np), 32'd1);
      @(negedge i_Clk);
      sw[3] = 1'b0;
      repeat (12) @(negedge i_Clk);
      sw[3] = 1'b1;
      wait_rise(1, 3, k);
      repeat (4) @(negedge i_Clk);
      sw[3] = 1'b0;
      repeat (7) @(posedge i_Clk);
      #1;
      chk("single_coinc_fall", 32'(bus_b.o_Fall[3]), 32'd1);
      chk("single_coinc_rep", 32'(bus_b.o_Repeat[3]), 32'd0);
      repeat (12) @(negedge i_Clk);

      // 6: lanes 0 and 2 at different offsets, reset mid-hold
      sw[0] = 1'b1;
      repeat (3) @(negedge i_Clk);
      sw[2] = 1'b1;
      repeat (12) @(negedge i_Clk);
      i_Rst_L = 1'b0;
      @(posedge i_Clk); #1;
      chk("midrst_a", 32'({bus_a.o_Switch, bus_a.o_Rise, bus_a.o_Fall, bus_a.o_Repeat}), 32'h0);
      chk("midrst_b", 32'({bus_b.o_Switch, bus_b.o_Rise, bus_b.o_Fall, bus_b.o_Repeat}), 32'h0);
      @(negedge i_Clk);
      sw = 4'h0;
      i_Rst_L = 1'b1;
      repeat (30) @(negedge i_Clk);

      // Random phase: mixed bounces and long holds per lane, occasional reset
      for (int l = 0; l < NCH; l++) hold_left[l] = 0;
      for (int c = 0; c < 4000; c++) begin
         for (int l = 0; l < NCH; l++) begin
            if (hold_left[l] == 0) begin
               sw[l] = 1'($urandom_range(0, 1));
               hold_left[l] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                          : int'($urandom_range(1, 6));
            end else begin
               hold_left[l]--;
            end
         end
         i_Rst_L = ($urandom_range(0, 499) != 0);
         @(negedge i_Clk);
      end
      i_Rst_L = 1'b1;
      repeat (5) @(negedge i_Clk);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
